// File: rtl/multicycle_control.sv
// Main control unit for the multicycle MIPS-subset CPU.
// Moore FSM: datapath controls decode from the current state only, except that
// the FETCH-state IR/PC loads wait for mem_ready. While reset is low every
// output, including the debug state, is held at zero.
module multicycle_control #(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    opcode,
   input  logic [OP_W-1:0]    funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               branch,
   output logic               ir_write,
   output logic               instr_mem_enable,
   output logic               data_mem_enable,
   output logic               mem_write,
   output logic               reg_file_enable,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         alu_control,
   output logic [1:0]         pc_source,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      FETCH  = STATE_W'(0),
      DECODE = STATE_W'(1),
      MEMADR = STATE_W'(2),
      MEMRD  = STATE_W'(3),
      MEMWB  = STATE_W'(4),
      MEMWR  = STATE_W'(5),
      EXEC   = STATE_W'(6),
      ALUWB  = STATE_W'(7),
      BRANCH = STATE_W'(8),
      ADDIEX = STATE_W'(9),
      ADDIWB = STATE_W'(10),
      JUMP   = STATE_W'(11)
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

   localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
   localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
   localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
   localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
   localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // The zero flag is combined with branch inside the datapath, not here.
   logic unused_zero;
   assign unused_zero = zero;

   state_t     state_reg, state_next;
   logic       funct_legal;
   logic [2:0] funct_alu;

   logic       pc_write_dec, branch_dec, ir_write_dec, instr_mem_enable_dec;
   logic       data_mem_enable_dec, mem_write_dec, reg_file_enable_dec;
   logic       reg_dst_dec, mem_to_reg_dec, alu_src_a_dec;
   logic [1:0] alu_src_b_dec, pc_source_dec;
   logic [2:0] alu_control_dec;
   logic       instr_done_dec, illegal_op_dec;

   // Map the R-type funct field onto an ALU operation and flag unsupported ones.
   always_comb begin
      funct_legal = 1'b1;
      funct_alu   = ALU_ADD;
      case (funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_legal = 1'b0;
      endcase
   end

   // State register; reset aborts any instruction in flight and returns to FETCH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= FETCH;
      else        state_reg <= state_next;
   end

   // Next-state and per-state control decode; anything not set for a state stays 0.
   always_comb begin
      state_next           = FETCH;
      pc_write_dec         = 1'b0;
      branch_dec           = 1'b0;
      ir_write_dec         = 1'b0;
      instr_mem_enable_dec = 1'b0;
      data_mem_enable_dec  = 1'b0;
      mem_write_dec        = 1'b0;
      reg_file_enable_dec  = 1'b0;
      reg_dst_dec          = 1'b0;
      mem_to_reg_dec       = 1'b0;
      alu_src_a_dec        = 1'b0;
      alu_src_b_dec        = 2'b00;
      alu_control_dec      = 3'b000;
      pc_source_dec        = 2'b00;
      instr_done_dec       = 1'b0;
      illegal_op_dec       = 1'b0;
      case (state_reg)
         FETCH: begin
            instr_mem_enable_dec = 1'b1;
            alu_src_b_dec        = 2'b01;
            alu_control_dec      = ALU_ADD;
            ir_write_dec         = mem_ready;
            pc_write_dec         = mem_ready;
            state_next           = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            // Branch target PC + (imm << 2) is computed here speculatively.
            alu_src_b_dec   = 2'b11;
            alu_control_dec = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE: begin
                  if (funct_legal) state_next = EXEC;
                  else             illegal_op_dec = 1'b1;
               end
               OP_BEQ:  state_next = BRANCH;
               OP_ADDI: state_next = ADDIEX;
               OP_J:    state_next = JUMP;
               default: illegal_op_dec = 1'b1;
            endcase
         end
         MEMADR: begin
            alu_src_a_dec   = 1'b1;
            alu_src_b_dec   = 2'b10;
            alu_control_dec = ALU_ADD;
            if (opcode == OP_LW)      state_next = MEMRD;
            else if (opcode == OP_SW) state_next = MEMWR;
         end
         MEMRD: begin
            data_mem_enable_dec = 1'b1;
            state_next          = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            reg_file_enable_dec = 1'b1;
            mem_to_reg_dec      = 1'b1;
            instr_done_dec      = 1'b1;
         end
         MEMWR: begin
            data_mem_enable_dec = 1'b1;
            mem_write_dec       = 1'b1;
            instr_done_dec      = mem_ready;
            state_next          = mem_ready ? FETCH : MEMWR;
         end
         EXEC: begin
            alu_src_a_dec   = 1'b1;
            alu_control_dec = funct_alu;
            state_next      = ALUWB;
         end
         ALUWB: begin
            reg_file_enable_dec = 1'b1;
            reg_dst_dec         = 1'b1;
            instr_done_dec      = 1'b1;
         end
         BRANCH: begin
            alu_src_a_dec   = 1'b1;
            alu_control_dec = ALU_SUB;
            branch_dec      = 1'b1;
            pc_source_dec   = 2'b01;
            instr_done_dec  = 1'b1;
         end
         ADDIEX: begin
            alu_src_a_dec   = 1'b1;
            alu_src_b_dec   = 2'b10;
            alu_control_dec = ALU_ADD;
            state_next      = ADDIWB;
         end
         ADDIWB: begin
            reg_file_enable_dec = 1'b1;
            instr_done_dec      = 1'b1;
         end
         JUMP: begin
            pc_write_dec   = 1'b1;
            pc_source_dec  = 2'b10;
            instr_done_dec = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

   // Outputs are forced low for as long as reset is held.
   always_comb begin
      pc_write         = reset & pc_write_dec;
      branch           = reset & branch_dec;
      ir_write         = reset & ir_write_dec;
      instr_mem_enable = reset & instr_mem_enable_dec;
      data_mem_enable  = reset & data_mem_enable_dec;
      mem_write        = reset & mem_write_dec;
      reg_file_enable  = reset & reg_file_enable_dec;
      reg_dst          = reset & reg_dst_dec;
      mem_to_reg       = reset & mem_to_reg_dec;
      alu_src_a        = reset & alu_src_a_dec;
      alu_src_b        = reset ? alu_src_b_dec : 2'b00;
      alu_control      = reset ? alu_control_dec : 3'b000;
      pc_source        = reset ? pc_source_dec : 2'b00;
      instr_done       = reset & instr_done_dec;
      illegal_op       = reset & illegal_op_dec;
      state            = reset ? state_reg : '0;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class state by
// state and compares the full control word against hand-derived values.
module tb_multicycle_control;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, branch, ir_write, instr_mem_enable, data_mem_enable;
   logic       mem_write, reg_file_enable, reg_dst, mem_to_reg, alu_src_a;
   logic [1:0] alu_src_b, pc_source;
   logic [2:0] alu_control;
   logic       instr_done, illegal_op;
   logic [3:0] state;

   int tests_run = 0;
   int tests_failed = 0;

   multicycle_control #(.OP_W(6), .STATE_W(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .opcode           (opcode),
      .funct            (funct),
      .zero             (zero),
      .mem_ready        (mem_ready),
      .pc_write         (pc_write),
      .branch           (branch),
      .ir_write         (ir_write),
      .instr_mem_enable (instr_mem_enable),
      .data_mem_enable  (data_mem_enable),
      .mem_write        (mem_write),
      .reg_file_enable  (reg_file_enable),
      .reg_dst          (reg_dst),
      .mem_to_reg       (mem_to_reg),
      .alu_src_a        (alu_src_a),
      .alu_src_b        (alu_src_b),
      .alu_control      (alu_control),
      .pc_source        (pc_source),
      .instr_done       (instr_done),
      .illegal_op       (illegal_op),
      .state            (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the next falling edge; inputs change and outputs are sampled there.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   // Compare the whole control word {state, pcw, br, irw, ime, dme, mw, rfe, rd, m2r, asa, asb, alc, pcs, done, ill}.
   task automatic expect_ctrl(input string tag, input logic [3:0] st,
                              input logic pcw, input logic br, input logic irw,
                              input logic ime, input logic dme, input logic mw,
                              input logic rfe, input logic rd, input logic m2r,
                              input logic asa, input logic [1:0] asb,
                              input logic [2:0] alc, input logic [1:0] pcs,
                              input logic done, input logic ill);
      logic [22:0] obs, exp;
      #1;
      obs = {state, pc_write, branch, ir_write, instr_mem_enable, data_mem_enable,
             mem_write, reg_file_enable, reg_dst, mem_to_reg, alu_src_a,
             alu_src_b, alu_control, pc_source, instr_done, illegal_op};
      exp = {st, pcw, br, irw, ime, dme, mw, rfe, rd, m2r, asa, asb, alc, pcs, done, ill};
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
      end
      $display("[TB] %-14s state=%0d word=%06h", tag, state, obs);
   endtask

   initial begin
      reset = 1'b0; mem_ready = 1'b0; opcode = 6'b100011; funct = 6'b000000; zero = 1'b0;

      // Held in reset: everything zero.
      next_cycle();
      expect_ctrl("reset_hold", 4'd0, 0,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);

      // Release with a slow instruction memory: FETCH stalls, no IR/PC load.
      reset = 1'b1;
      expect_ctrl("fetch_stall", 4'd0, 0,0,0,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("fetch_stall2", 4'd0, 0,0,0,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);

      // lw: 0,1,2,3,4,0
      mem_ready = 1'b1;
      expect_ctrl("lw_fetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("lw_decode", 4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("lw_memadr", 4'd2, 0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("lw_memrd", 4'd3, 0,0,0,0,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("lw_memwb", 4'd4, 0,0,0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 1,0);

      // R-type sub: 0,1,6,7,0
      next_cycle();
      opcode = 6'b000000; funct = 6'b100010;
      expect_ctrl("sub_fetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("sub_decode", 4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("sub_exec", 4'd6, 0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("sub_aluwb", 4'd7, 0,0,0,0,0,0,1,1,0,0, 2'b00, 3'b000, 2'b00, 1,0);

      // R-type or, aborted by reset in EXEC.
      next_cycle();
      funct = 6'b100101;
      expect_ctrl("or_fetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
      next_cycle();
      next_cycle();
      expect_ctrl("or_exec", 4'd6, 0,0,0,0,0,0,0,0,0,1, 2'b00, 3'b001, 2'b00, 0,0);
      reset = 1'b0;
      expect_ctrl("reset_in_exec", 4'd0, 0,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("reset_held", 4'd0, 0,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
      reset = 1'b1;
      opcode = 6'b101011;
      expect_ctrl("rel_fetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);

      // sw with data memory stalled 3 cycles in MEMWR.
      next_cycle();
      expect_ctrl("sw_decode", 4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("sw_memadr", 4'd2, 0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0);
      next_cycle();
      mem_ready = 1'b0;
      expect_ctrl("sw_memwr_st1", 4'd5, 0,0,0,0,1,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("sw_memwr_st2", 4'd5, 0,0,0,0,1,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("sw_memwr_st3", 4'd5, 0,0,0,0,1,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 0,0);
      next_cycle();
      mem_ready = 1'b1;
      expect_ctrl("sw_memwr_done", 4'd5, 0,0,0,0,1,1,0,0,0,0, 2'b00, 3'b000, 2'b00, 1,0);

      // beq: 0,1,8
      next_cycle();
      opcode = 6'b000100; zero = 1'b1;
      expect_ctrl("beq_fetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("beq_decode", 4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("beq_branch", 4'd8, 0,1,0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 1,0);

      // j: 0,1,11
      next_cycle();
      opcode = 6'b000010; zero = 1'b0;
      expect_ctrl("j_fetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
      next_cycle();
      next_cycle();
      expect_ctrl("j_jump", 4'd11, 1,0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 1,0);

      // addi: 0,1,9,10
      next_cycle();
      opcode = 6'b001000;
      expect_ctrl("addi_fetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
      next_cycle();
      next_cycle();
      expect_ctrl("addi_exec", 4'd9, 0,0,0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("addi_wb", 4'd10, 0,0,0,0,0,0,1,0,0,0, 2'b00, 3'b000, 2'b00, 1,0);

      // Illegal opcode 111111: pulse in DECODE, back to FETCH.
      next_cycle();
      opcode = 6'b111111;
      expect_ctrl("illop_fetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);
      next_cycle();
      expect_ctrl("illop_decode", 4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,1);
      next_cycle();
      opcode = 6'b000000; funct = 6'b000111;
      expect_ctrl("illop_refetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);

      // Illegal R-type funct 000111.
      next_cycle();
      expect_ctrl("illfn_decode", 4'd1, 0,0,0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0,1);
      next_cycle();
      expect_ctrl("illfn_refetch", 4'd0, 1,0,1,1,0,0,0,0,0,0, 2'b01, 3'b010, 2'b00, 0,0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control unit for the 32-bit multicycle MIPS-subset CPU.
- A Moore FSM that reads opcode/funct from the instruction register output and the ALU zero flag.
- Drives every control input of the datapath: pc_write, ir_write, branch, alu_src_a/b, alu_control, pc_source, register-file and memory enables.
- Adds a mem_ready handshake so fetch and data-memory states can stall on slow memories.

Parameters:
- OP_W, 6, opcode/funct field width
- STATE_W, 4, state register width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (observed by datapath through the branch signal)
- mem_ready  in  1  instruction/data memory access complete this cycle
- pc_write  out  1  unconditional PC load
- branch  out  1  conditional PC load; datapath forms pc_enable = pc_write | (branch & zero)
- ir_write  out  1  IR load
- instr_mem_enable  out  1  instruction memory access
- data_mem_enable  out  1  data memory access
- mem_write  out  1  data memory write (1) / read (0)
- reg_file_enable  out  1  register file write
- reg_dst  out  1  write register: 1 = rd, 0 = rt
- mem_to_reg  out  1  write data: 1 = memory data, 0 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode or funct
- state  out  4  current state, for debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge.
- Reset: while reset=0, state=FETCH asynchronously and all outputs are forced to 0, including state. Releasing reset starts a fetch on the first clk edge. Reset mid-instruction aborts it; no partial writes are issued after reset asserts.
- Outputs are decoded from state only (Moore). Exceptions: ir_write and pc_write in FETCH are qualified by mem_ready. Any output not listed for a state is 0.
- FETCH:
  - instr_mem_enable=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, add (precomputes branch target).
  - Next state by opcode: 100011 lw or 101011 sw -> MEMADR; 000000 R-type -> EXEC; 000100 beq -> BRANCH; 001000 addi -> ADDIEX; 000010 j -> JUMP.
  - R-type with funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt} is illegal.
  - Illegal opcode/funct: illegal_op=1, next FETCH, no state writes.
- MEMADR: a=1, b=10, add. Next MEMRD for lw, MEMWR for sw.
- MEMRD: data_mem_enable=1, mem_write=0. Holds until mem_ready, then MEMWB.
- MEMWB: reg_file_enable=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next FETCH.
- MEMWR: data_mem_enable=1, mem_write=1 held until mem_ready. instr_done=mem_ready. Next FETCH when mem_ready=1.
- EXEC: a=1, b=00, alu_control from funct (add 010, sub 110, and 000, or 001, slt 111). Next ALUWB.
- ALUWB: reg_file_enable=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next FETCH.
- BRANCH: a=1, b=00, alu_control=110, branch=1, pc_source=01, instr_done=1. Next FETCH.
- ADDIEX: a=1, b=10, add. Next ADDIWB.
- ADDIWB: reg_file_enable=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Next FETCH.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each stall cycle adds one cycle.
- Timing assumption: opcode/funct are stable from DECODE to the end of the instruction, because the IR is written only in FETCH.

Test Plan:
- Reset: reset=0 mid-EXEC -> all outputs 0 and state=0 immediately. Release reset with mem_ready=1 -> first cycle has ir_write=1, pc_write=1, alu_src_b=01.
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0. MEMWB shows reg_file_enable=1, mem_to_reg=1, reg_dst=0, instr_done=1.
- R-type sub (funct 100010) -> states 0,1,6,7. EXEC alu_control=110. ALUWB reg_dst=1 with one-cycle instr_done.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write=1 held 4 cycles. instr_done pulses only in the cycle mem_ready=1; then FETCH.
- beq then j -> BRANCH shows branch=1, pc_source=01, alu_control=110. JUMP shows pc_write=1, pc_source=10. Each takes 3 cycles.
- Illegal opcode 111111 and R-type funct 000111 -> illegal_op pulses in DECODE. Next state FETCH; reg_file_enable and data_mem_enable never assert.
